serial_adder_ctrl: RTL

//  Bit-serial adder controller. Sequences one shared 1-bit add cell (two half-adder

---
 rtl/serial_adder_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder controller.
// One shared 1-bit add cell is stepped across WIDTH clock cycles, LSB first.
// Handshake: start is accepted in IDLE or DONE; busy covers the SHIFT phase;
// done pulses for one cycle when sum/carry are refreshed.

// Half adder: the building block of the shared add cell.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

// One-bit full add built from two half-adder stages plus a carry OR.
module serial_add_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic s1, c1, c2;

    half_adder u_ha0 (.a(a),  .b(b),  .s(s1), .c(c1));
    half_adder u_ha1 (.a(s1), .b(ci), .s(s),  .c(c2));

    assign co = c1 | c2;
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] ip1,
    input  logic [WIDTH-1:0] ip2,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             busy,
    output logic             done
);
    // Counter wide enough to hold WIDTH-1 with a spare bit; never wraps in use.
    localparam int            CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             c_q;
    logic [CW-1:0]    cnt;

    logic             bit_s;
    logic             bit_c;
    logic [WIDTH-1:0] res_next;

    // The single shared add cell always looks at the operand LSBs.
    serial_add_cell u_cell (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .ci (c_q),
        .s  (bit_s),
        .co (bit_c)
    );

    // New sum bit enters at the MSB so after WIDTH steps bit 0 is at the LSB.
    assign res_next = {bit_s, res_sr[WIDTH-1:1]};

    // Controller FSM: captures operands, steps the cell, publishes the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            c_q    <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            carry  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr   <= ip1;
                        b_sr   <= ip2;
                        c_q    <= cin;
                        res_sr <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    // start and the operand inputs are ignored here.
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_next;
                    c_q    <= bit_c;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        // Outputs change only here, so no partial sum is visible.
                        sum   <= res_next;
                        carry <= bit_c;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Back-to-back add: skip IDLE entirely.
                        a_sr   <= ip1;
                        b_sr   <= ip2;
                        c_q    <= cin;
                        res_sr <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
